// File: rtl/ext_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : ext_bus_arbiter_if
// Desc   : Requester-side and pin-side signal bundle of ext_bus_arbiter.
// Rev    : 1.0
// ============================================================================
interface ext_bus_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  xaddr;
    logic [7:0]  xdout;
    logic [7:0]  xoe;
    logic [7:0]  xdin;
    logic        xsync;
    logic        xwe;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, xdin,
        output ack0, ack1, rdata, busy, xaddr, xdout, xoe, xsync, xwe
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, xdin,
        input  ack0, ack1, rdata, busy, xaddr, xdout, xoe, xsync, xwe
    );
endinterface
`default_nettype wire

// File: rtl/ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ext_bus_arbiter
// Desc   : Shares one byte-serial pin bus between two 32-bit requesters.
//          Define EXTBUS_RR_EN for round-robin arbitration (fixed otherwise).
// Rev    : 1.0
// ============================================================================
module ext_bus_arbiter #(
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    ext_bus_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] c_TURN_LAST = 3'(TURNAROUND - 1);
    localparam bit         c_SKIP_TURN = (TURNAROUND == 0);

    logic [2:0]  r_state;
    logic [1:0]  r_bc;
    logic [2:0]  r_tc;
    logic        r_id;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [23:0] r_shadow;

    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata;
    logic        r_busy;
    logic [7:0]  r_xaddr;
    logic [7:0]  r_xdout;
    logic [7:0]  r_xoe;
    logic        r_xsync;
    logic        r_xwe;

    logic        w_any_req;
    logic        w_win;
    logic [2:0]  w_state_nxt;
    logic [1:0]  w_bc_nxt;
    logic [2:0]  w_tc_nxt;
    logic        w_id_nxt;
    logic        w_we_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;

    logic        w_ack0_nxt;
    logic        w_ack1_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_busy_nxt;
    logic [7:0]  w_xaddr_nxt;
    logic [7:0]  w_xdout_nxt;
    logic [7:0]  w_xoe_nxt;
    logic        w_xsync_nxt;
    logic        w_xwe_nxt;

`ifdef EXTBUS_RR_EN
    logic r_last;

    // Reset to 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last <= w_win;
        end
    end

    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            w_win = ~r_last;
        end else begin
            w_win = ~bus.req0;
        end
    end
`else
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_win     = ~bus.req0;
    end
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bc     <= 2'd0;
            r_tc     <= 3'd0;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_shadow <= 24'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bc    <= w_bc_nxt;
            r_tc    <= w_tc_nxt;
            r_id    <= w_id_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            // Byte 3 goes straight into rdata, so only bytes 0..2 are shadowed.
            if (r_state == S_RDATA) begin
                case (r_bc)
                    2'd0:    r_shadow[7:0]   <= bus.xdin;
                    2'd1:    r_shadow[15:8]  <= bus.xdin;
                    2'd2:    r_shadow[23:16] <= bus.xdin;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_bc_nxt    = r_bc;
        w_tc_nxt    = r_tc;
        w_id_nxt    = r_id;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ADDR;
                    w_bc_nxt    = 2'd0;
                    w_id_nxt    = w_win;
                    w_we_nxt    = w_win ? bus.we1    : bus.we0;
                    w_addr_nxt  = w_win ? bus.addr1  : bus.addr0;
                    w_wdata_nxt = w_win ? bus.wdata1 : bus.wdata0;
                end
            end
            S_ADDR: begin
                w_bc_nxt = r_bc + 2'd1;
                if (r_bc == 2'd3) begin
                    if (r_we) begin
                        w_state_nxt = S_WDATA;
                    end else if (c_SKIP_TURN) begin
                        w_state_nxt = S_RDATA;
                    end else begin
                        w_state_nxt = S_TURN;
                        w_tc_nxt    = 3'd0;
                    end
                end
            end
            S_WDATA: begin
                w_bc_nxt = r_bc + 2'd1;
                if (r_bc == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_TURN: begin
                if (r_tc == c_TURN_LAST) begin
                    w_state_nxt = S_RDATA;
                    w_tc_nxt    = 3'd0;
                end else begin
                    w_tc_nxt = r_tc + 3'd1;
                end
            end
            S_RDATA: begin
                w_bc_nxt = r_bc + 2'd1;
                if (r_bc == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bc_nxt    = 2'd0;
                w_tc_nxt    = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so every pin is a flop
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_xwe_nxt   = (w_state_nxt != S_IDLE) && w_we_nxt;
        w_xsync_nxt = (w_state_nxt == S_ADDR) && (w_bc_nxt == 2'd0);
        w_xaddr_nxt = 8'h00;
        w_xdout_nxt = 8'h00;
        w_xoe_nxt   = 8'h00;
        if (w_state_nxt == S_ADDR) begin
            w_xaddr_nxt = w_addr_nxt[{w_bc_nxt, 3'b000} +: 8];
        end
        if (w_state_nxt == S_WDATA) begin
            w_xdout_nxt = w_wdata_nxt[{w_bc_nxt, 3'b000} +: 8];
            w_xoe_nxt   = 8'hFF;
        end
        w_ack0_nxt  = (w_state_nxt == S_DONE) && !w_id_nxt;
        w_ack1_nxt  = (w_state_nxt == S_DONE) &&  w_id_nxt;
        w_rdata_nxt = r_rdata;
        if (r_state == S_RDATA && r_bc == 2'd3) begin
            w_rdata_nxt = {bus.xdin, r_shadow};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdata <= 32'd0;
            r_busy  <= 1'b0;
            r_xaddr <= 8'h00;
            r_xdout <= 8'h00;
            r_xoe   <= 8'h00;
            r_xsync <= 1'b0;
            r_xwe   <= 1'b0;
        end else begin
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
            r_rdata <= w_rdata_nxt;
            r_busy  <= w_busy_nxt;
            r_xaddr <= w_xaddr_nxt;
            r_xdout <= w_xdout_nxt;
            r_xoe   <= w_xoe_nxt;
            r_xsync <= w_xsync_nxt;
            r_xwe   <= w_xwe_nxt;
        end
    end

    assign bus.ack0  = r_ack0;
    assign bus.ack1  = r_ack1;
    assign bus.rdata = r_rdata;
    assign bus.busy  = r_busy;
    assign bus.xaddr = r_xaddr;
    assign bus.xdout = r_xdout;
    assign bus.xoe   = r_xoe;
    assign bus.xsync = r_xsync;
    assign bus.xwe   = r_xwe;
endmodule
`default_nettype wire

// File: doc/ext_bus_arbiter.md
# ext_bus_arbiter

Byte-serial external bus controller that shares the chip's single 8-bit pin bus between two 32-bit requesters (instruction-fetch port 0, load/store port 1). It grants one requester at a time, then sequences the transaction as byte phases: 4 address bytes, then either 4 write-data bytes or a turnaround followed by 4 read-data bytes. It sits between the CPU core and the top-level pin wrapper, and replaces the free-running phase counter with a request/acknowledge-driven scheduler.

## Interface
- TURNAROUND, default 1: idle cycles between the last address phase and the first read-data phase. Legal range 0..7.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  transaction request. Held with its fields until the matching ack.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  32 each  transaction address.
- wdata0, wdata1  in  32 each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- rdata  out  32  read data. Valid in the ack cycle of a read; held until the next read completes.
- busy  out  1  high in every state except IDLE.
- xaddr  out  8  address byte lane. Zero outside ADDR.
- xdout  out  8  write-data byte lane. Zero outside WDATA.
- xoe  out  8  data-lane output enable. 8'hFF in WDATA, 8'h00 otherwise.
- xdin  in  8  read-data byte lane.
- xsync  out  1  high only in the first ADDR cycle.
- xwe  out  1  direction of the current transaction. Zero in IDLE.

## Operation
- States: IDLE, ADDR, WDATA, TURN, RDATA, DONE. A 2-bit byte counter `bc` runs within ADDR, WDATA and RDATA. A 3-bit counter runs within TURN.
- **IDLE**
  - If any request is high: latch the winner's id, we, addr and wdata. Go to ADDR with bc = 0.
  - If no request is high: stay in IDLE.
- **ADDR**
  - xaddr = addr[8*bc+7 : 8*bc]. Byte order is little-endian, byte 0 first.
  - After bc = 3: go to WDATA if we = 1, otherwise go to TURN.
  - If TURNAROUND = 0, skip TURN and go directly to RDATA.
- **WDATA**
  - xdout = wdata byte bc, xoe = 8'hFF.
  - After bc = 3: go to DONE.
- **TURN**
  - Lasts TURNAROUND cycles, with xoe = 0. Then go to RDATA.
- **RDATA**
  - On each clock edge, xdin is captured into shadow byte bc.
  - After bc = 3: go to DONE.
- **DONE**
  - Pulse ack of the granted requester for one cycle.
  - For a read, update rdata from the shadow register (rdata and ack are registered together).
  - Return to IDLE. Requests are evaluated again only in IDLE, so there is always at least one IDLE cycle between transactions.
- Latched fields are used for the whole transaction. Request inputs changing mid-transaction have no effect.
- A requester that drops req mid-transaction still receives its ack. The transaction always completes.
- A requester must deassert req in the cycle after ack unless it wants another transaction. If req is still high in the next IDLE cycle, that counts as a new request.
- Reset, asynchronous, at any time including mid-transaction:
  - state goes to IDLE; bc and the TURN counter go to 0.
  - Outputs go to: ack0 = ack1 = 0, rdata = 0, busy = 0, xaddr = 0, xdout = 0, xoe = 0, xsync = 0, xwe = 0.
  - The grant pointer is reset so that requester 0 wins the first contention.
  - An interrupted transaction is dropped with no ack.

## Timing
- All outputs are registered and change only on the rising edge of clk, except during asynchronous reset.
- Request sampled in IDLE at edge T. The first ADDR cycle, with xsync high, starts after edge T.
- Write: ADDR for cycles 1–4, WDATA for 5–8, DONE/ack in cycle 9. Total 9 cycles from the grant edge.
- Read: ADDR for 1–4, TURN for 5..4+TURNAROUND, RDATA for the next 4, then DONE. Total 9+TURNAROUND cycles.
- Read sampling: xdin is sampled at the rising edge that ends each RDATA cycle. The external device must drive byte bc during RDATA cycle bc.
- Minimum request-to-request period: 10 cycles for writes, 10+TURNAROUND for reads. This includes the mandatory IDLE cycle.

## Configuration
- EXTBUS_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, the requester not granted last wins.
  - The grant pointer updates on every grant.
- EXTBUS_RR_EN undefined: fixed priority.
  - Requester 0 always wins simultaneous requests.
  - The grant pointer logic is absent.
- A single request is granted immediately in both modes.

## Test plan
- Write, port 0: addr0 = 32'h12345678, wdata0 = 32'hCAFEF00D.
  - xaddr = 78, 56, 34, 12 in cycles 1–4.
  - xdout = 0D, F0, FE, CA in cycles 5–8, with xoe = FF.
  - ack0 pulses in cycle 9.
- Read, port 1, TURNAROUND = 1: bench drives xdin = EF, BE, AD, DE in RDATA cycles 0–3.
  - xoe = 00 throughout.
  - ack1 pulses in cycle 10 with rdata = 32'hDEADBEEF.
- Contention: req0 and req1 held high for 3 transactions.
  - With EXTBUS_RR_EN: grant order 0, 1, 0.
  - Without EXTBUS_RR_EN: 0, 0, 0.
  - Each gap between transactions is exactly 1 IDLE cycle.
- Request dropped: req0 deasserted during ADDR cycle 2. Transaction completes and ack0 still pulses.
- Reset mid-write: rst_n low during WDATA cycle 6.
  - All outputs go to 0 immediately; no ack follows.
  - After release, a new req1 transaction starts cleanly with xsync high in its first ADDR cycle.
- TURNAROUND = 0 read: RDATA starts in cycle 5 and ack arrives in cycle 9.
